// File: rtl/cpu15_seq_pkg.sv
// Shared definitions for the cpu15 phase sequencer: state and halt-cause
// encodings plus default parameter values.
package cpu15_seq_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_FT   = 3'd1,
        ST_DC   = 3'd2,
        ST_EX   = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RST  = 2'd0,
        CAUSE_HLT  = 2'd1,
        CAUSE_STOP = 2'd2,
        CAUSE_BP   = 2'd3
    } cause_t;

    localparam logic [3:0] HLT_OPCODE_DEF = 4'b1111;
    localparam int         CNT_W_DEF      = 16;

endpackage

// File: rtl/cpu15_seq.sv
// Single-clock instruction-phase sequencer for cpu15: one-hot stage enables,
// run/stop/step control, PC breakpoint, RAM wait stalls and a retire counter.
module cpu15_seq
    import cpu15_seq_pkg::*;
#(
    parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DEF,
    parameter int         CNT_W      = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STOP,
    input  logic             STEP,
    input  logic [3:0]       OP_CODE,
    input  logic [7:0]       P_COUNT,
    input  logic             RAM_ACC,
    input  logic             RAM_RDY,
    input  logic             BP_EN,
    input  logic [7:0]       BP_ADDR,
    output logic             EN_FT,
    output logic             EN_DC,
    output logic             EN_EX,
    output logic             EN_WB,
    output logic             RUNNING,
    output logic [1:0]       HALT_CAUSE,
    output logic [CNT_W-1:0] RETIRED
);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic             step_mode_q, step_mode_d;
    logic             stop_pend_q, stop_pend_d;
    logic             bp_skip_q, bp_skip_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ram_wait;

    assign ram_wait = RAM_ACC && !RAM_RDY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cause_q     <= CAUSE_RST;
            step_mode_q <= 1'b0;
            stop_pend_q <= 1'b0;
            bp_skip_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            cause_q     <= cause_d;
            step_mode_q <= step_mode_d;
            stop_pend_q <= stop_pend_d;
            bp_skip_q   <= bp_skip_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        step_mode_d = step_mode_q;
        stop_pend_d = stop_pend_q;
        bp_skip_d   = bp_skip_q;
        retired_d   = retired_q;
        case (state_q)
            ST_HALT: begin
                if (RUN || STEP) begin
                    state_d     = ST_FT;
                    step_mode_d = !RUN;
                    // Let the halting PC through once after a breakpoint stop.
                    if (cause_q == CAUSE_BP) begin
                        bp_skip_d = 1'b1;
                    end
                end
            end
            ST_FT: begin
                bp_skip_d = 1'b0;
                if (BP_EN && (P_COUNT == BP_ADDR) && !bp_skip_q) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else begin
                    state_d = ST_DC;
                end
            end
            ST_DC: begin
                if (!ram_wait) begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (!ram_wait) begin
                    retired_d = retired_q + CNT_W'(1);
                    if (OP_CODE == HLT_OPCODE) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_HLT;
                    end else if (stop_pend_q || STOP || step_mode_q) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_STOP;
                    end else begin
                        state_d = ST_FT;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        // A STOP landing on the completing WB is consumed by the halt above.
        if (state_q != ST_HALT && STOP) begin
            stop_pend_d = 1'b1;
        end
        if (state_q != ST_HALT && state_d == ST_HALT) begin
            stop_pend_d = 1'b0;
        end
    end

    always_comb begin
        EN_FT      = (state_q == ST_FT);
        EN_DC      = (state_q == ST_DC);
        EN_EX      = (state_q == ST_EX);
        EN_WB      = (state_q == ST_WB);
        RUNNING    = (state_q != ST_HALT);
        HALT_CAUSE = cause_q;
        RETIRED    = retired_q;
    end

endmodule

// File: tb/tb_cpu15_seq.sv
// Self-checking bench for cpu15_seq: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_cpu15_seq;

    localparam int TB_CNT_W = 4;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                RUN = 1'b0, STOP = 1'b0, STEP = 1'b0;
    logic [3:0]          OP_CODE = 4'h0;
    logic [7:0]          P_COUNT = 8'h00;
    logic                RAM_ACC = 1'b0, RAM_RDY = 1'b0;
    logic                BP_EN = 1'b0;
    logic [7:0]          BP_ADDR = 8'h00;
    logic                EN_FT, EN_DC, EN_EX, EN_WB, RUNNING;
    logic [1:0]          HALT_CAUSE;
    logic [TB_CNT_W-1:0] RETIRED;

    int checks = 0;
    int errors = 0;

    // Reference model state (instruction level)
    int retired_m = 0;
    int cause_m   = 0;
    bit step_m    = 0;
    bit halted_m  = 1;

    cpu15_seq #(.HLT_OPCODE(4'hF), .CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STOP(STOP), .STEP(STEP),
        .OP_CODE(OP_CODE), .P_COUNT(P_COUNT), .RAM_ACC(RAM_ACC), .RAM_RDY(RAM_RDY),
        .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .EN_FT(EN_FT), .EN_DC(EN_DC),
        .EN_EX(EN_EX), .EN_WB(EN_WB), .RUNNING(RUNNING), .HALT_CAUSE(HALT_CAUSE),
        .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Leave HALT by a RUN and/or STEP pulse; the next cycle must be FT.
    task automatic start(input bit run, input bit step);
        checks++;
        if (RUNNING !== 1'b0) begin
            errors++;
            $display("FAIL start_from_halt: running=%b required 0", RUNNING);
        end
        RUN = run;
        STEP = step;
        RAM_RDY = 1'($urandom_range(0, 1));
        tick();
        RUN = 1'b0;
        STEP = 1'b0;
        step_m = !run;
        halted_m = 0;
        $display("start run=%0b step=%0b", run, step);
    endtask

    // Execute one instruction from FT, checking every enable cycle and the
    // state reached after completion. stop_cyc < 0 means no STOP pulse.
    task automatic run_instr(input int dcs, input int wbs, input logic [3:0] op,
                             input int stop_cyc, input logic [7:0] pc);
        logic [3:0] q[$];
        logic [3:0] en;
        logic       acc;
        int         dcn = 0;
        int         wbn = 0;
        bit         stop_seen = 0;
        bit         halt_exp;
        q.push_back(4'b1000);
        for (int k = 0; k <= dcs; k++) q.push_back(4'b0100);
        q.push_back(4'b0010);
        for (int k = 0; k <= wbs; k++) q.push_back(4'b0001);
        acc = (dcs > 0 || wbs > 0) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int i = 0; i < q.size(); i++) begin
            en = {EN_FT, EN_DC, EN_EX, EN_WB};
            checks++;
            if (en !== q[i] || RUNNING !== 1'b1 || HALT_CAUSE !== 2'(cause_m)) begin
                errors++;
                $display("FAIL phase cyc=%0d: en=%b run=%b cause=%0d required en=%b run=1 cause=%0d",
                         i, en, RUNNING, HALT_CAUSE, q[i], cause_m);
            end
            P_COUNT = pc;
            OP_CODE = op;
            RAM_ACC = acc;
            STOP = (i == stop_cyc);
            RUN = 1'($urandom_range(0, 1));
            STEP = 1'($urandom_range(0, 1));
            if (!acc) begin
                RAM_RDY = 1'($urandom_range(0, 1));
            end else if (q[i] == 4'b0100) begin
                RAM_RDY = (dcn >= dcs);
                dcn++;
            end else if (q[i] == 4'b0001) begin
                RAM_RDY = (wbn >= wbs);
                wbn++;
            end else begin
                RAM_RDY = 1'($urandom_range(0, 1));
            end
            if (i == stop_cyc) stop_seen = 1;
            tick();
        end
        STOP = 1'b0;
        RUN = 1'b0;
        STEP = 1'b0;
        retired_m = (retired_m + 1) % (1 << TB_CNT_W);
        halt_exp = 1'b1;
        if (op == 4'hF) cause_m = 1;
        else if (stop_seen || step_m) cause_m = 2;
        else halt_exp = 1'b0;
        halted_m = halt_exp;
        en = {EN_FT, EN_DC, EN_EX, EN_WB};
        checks++;
        if (en !== (halt_exp ? 4'b0000 : 4'b1000) || RUNNING !== !halt_exp ||
            HALT_CAUSE !== 2'(cause_m) || RETIRED !== TB_CNT_W'(retired_m)) begin
            errors++;
            $display("FAIL instr_end: en=%b run=%b cause=%0d retired=%0d required halt=%0b cause=%0d retired=%0d",
                     en, RUNNING, HALT_CAUSE, RETIRED, halt_exp, cause_m, retired_m);
        end
        $display("instr pc=%0d op=%h dcs=%0d wbs=%0d stop=%0d -> halt=%0b cause=%0d retired=%0d",
                 pc, op, dcs, wbs, stop_cyc, halt_exp, cause_m, retired_m);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        RUN = 1'b1;
        STEP = 1'b1;
        tick();
        tick();
        RUN = 1'b0;
        STEP = 1'b0;
        RESET = 1'b0;
        retired_m = 0;
        cause_m = 0;
        halted_m = 1;
        checks++;
        if ({EN_FT, EN_DC, EN_EX, EN_WB} !== 4'b0000 || RUNNING !== 1'b0 ||
            HALT_CAUSE !== 2'd0 || RETIRED !== '0) begin
            errors++;
            $display("FAIL reset: en=%b run=%b cause=%0d retired=%0d required all 0",
                     {EN_FT, EN_DC, EN_EX, EN_WB}, RUNNING, HALT_CAUSE, RETIRED);
        end
        $display("reset checked");
    endtask

    task automatic test_run_basic();
        start(1, 0);
        for (int n = 0; n < 3; n++) run_instr(0, 0, 4'h0, -1, 8'(n));
        checks++;
        if (RETIRED !== TB_CNT_W'(3)) begin
            errors++;
            $display("FAIL run_basic_retired: retired=%0d required 3", RETIRED);
        end
        run_instr(0, 0, 4'h0, 2, 8'd3);
    endtask

    task automatic test_stop_in_halt();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        tick();
        checks++;
        if (RUNNING !== 1'b0 || HALT_CAUSE !== 2'(cause_m)) begin
            errors++;
            $display("FAIL stop_in_halt: run=%b cause=%0d required run=0 cause=%0d",
                     RUNNING, HALT_CAUSE, cause_m);
        end
        start(1, 1);
        run_instr(0, 0, 4'h1, -1, 8'd10);
        run_instr(1, 0, 4'h2, 4, 8'd11);
    endtask

    task automatic test_step();
        start(0, 1);
        run_instr(0, 0, 4'h3, -1, 8'd20);
    endtask

    task automatic test_ram_stall();
        start(0, 1);
        run_instr(3, 2, 4'h4, -1, 8'd30);
    endtask

    task automatic test_hlt();
        start(1, 0);
        run_instr(0, 0, 4'hF, 3, 8'd40);
        start(1, 0);
        run_instr(0, 1, 4'hF, -1, 8'd40);
    endtask

    task automatic test_breakpoint();
        BP_EN = 1'b1;
        BP_ADDR = 8'h05;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                start(1, 0);
                run_instr(0, 0, 4'h0, -1, 8'd3);
                run_instr(0, 0, 4'h0, -1, 8'd4);
            end else begin
                start(1, 0);
                run_instr(0, 0, 4'h0, -1, 8'd5);
                run_instr(0, 0, 4'h0, -1, 8'd6);
            end
            P_COUNT = 8'h05;
            tick();
            cause_m = 3;
            halted_m = 1;
            checks++;
            if ({EN_FT, EN_DC, EN_EX, EN_WB} !== 4'b0000 || RUNNING !== 1'b0 ||
                HALT_CAUSE !== 2'd3 || RETIRED !== TB_CNT_W'(retired_m)) begin
                errors++;
                $display("FAIL breakpoint: en=%b run=%b cause=%0d retired=%0d required halt cause=3 retired=%0d",
                         {EN_FT, EN_DC, EN_EX, EN_WB}, RUNNING, HALT_CAUSE, RETIRED, retired_m);
            end
            $display("breakpoint pass=%0d halted at pc=5", pass);
        end
        start(0, 1);
        run_instr(0, 0, 4'h0, -1, 8'd5);
        BP_EN = 1'b0;
    endtask

    task automatic test_reset_mid();
        start(1, 0);
        RAM_ACC = 1'b0;
        P_COUNT = 8'd50;
        tick();
        tick();
        checks++;
        if (EN_EX !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ex: en_ex=%b required 1", EN_EX);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        retired_m = 0;
        cause_m = 0;
        halted_m = 1;
        checks++;
        if ({EN_FT, EN_DC, EN_EX, EN_WB} !== 4'b0000 || RUNNING !== 1'b0 ||
            HALT_CAUSE !== 2'd0 || RETIRED !== '0) begin
            errors++;
            $display("FAIL reset_mid: en=%b run=%b cause=%0d retired=%0d required all 0",
                     {EN_FT, EN_DC, EN_EX, EN_WB}, RUNNING, HALT_CAUSE, RETIRED);
        end
        $display("reset during EX checked");
    endtask

    task automatic test_random();
        int dcs, wbs, stop_cyc;
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            if (halted_m) begin
                start(1'($urandom_range(0, 1)), 1'b1);
            end
            dcs = $urandom_range(0, 3);
            wbs = $urandom_range(0, 3);
            op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            stop_cyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3 + dcs + wbs)) : -1;
            run_instr(dcs, wbs, op, stop_cyc, 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_run_basic();
        test_stop_in_halt();
        test_step();
        test_ram_stall();
        test_hlt();
        test_breakpoint();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
